// File: rtl/uart_pkg.sv
// Shared UART timing helpers, bit-FSM encodings and word geometry
// for the debug serial link (uart_tx / uart_rx / serial2mem).
package uart_pkg;

  localparam int BYTES_PER_WORD = 6;
  localparam int WORD_W = 8 * BYTES_PER_WORD;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  function automatic int clks_per_bit(
    input int freq,
    input int baud
  );
    return (freq + baud / 2) / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/serial2mem_if.sv
// Ringbuffer write port: word, write strobe and full flag.
// master = serial2mem, slave = ringbuffer.
interface serial2mem_if;
  import uart_pkg::*;

  logic [WORD_W-1:0] write_data;
  logic              write_clock_enable;
  logic              overflow;

  modport master (
    output write_data,
    output write_clock_enable,
    input  overflow
  );

  modport slave (
    input  write_data,
    input  write_clock_enable,
    output overflow
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: rx synchronizer, bit FSM, byte/stop-error strobes.
// Strobes are combinational in the stop-sample cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_error,
  output logic       rx_busy
);

  localparam int HALF = half_bit(CLKS_PER_BIT);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          fall;
  logic          bit_end;
  logic          half_end;

  assign fall     = rx_d & ~rx_s;
  assign bit_end  = (cnt == FULL_LAST);
  assign half_end = (cnt == HALF_LAST);

  assign byte_data  = shreg;
  assign byte_valid = (state == ST_STOP) && bit_end && rx_s;
  assign stop_error = (state == ST_STOP) && bit_end && !rx_s;
  assign rx_busy    = (state == ST_START) ||
                      (state == ST_DATA)  ||
                      (state == ST_STOP);

  // Sync flops reset high so an idle line is not seen as a start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (half_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial2mem.sv
// Debug-link receive path: packs uart_rx bytes into 48-bit words
// and writes them to the ringbuffer, with timeout and overflow drop.
module serial2mem
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ   = 12000000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  serial2mem_if.master bus,
  output logic frame_error,
  output logic word_dropped,
  output logic rx_busy
);

  localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int LIMIT = TIMEOUT_BITS * CPB;
  localparam int TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(LIMIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              stop_error;
  logic [2:0]        byte_count;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] next_word;
  logic [TW-1:0]     idle_cnt;
  logic              partial;
  logic              timeout;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .stop_error(stop_error),
    .rx_busy   (rx_busy)
  );

  assign next_word = {word[WORD_W-9:0], byte_data};
  assign partial   = !rx_busy && (byte_count != '0);
  assign timeout   = partial && (idle_cnt == IDLE_LAST);

  // Idle counter only runs between bytes of an unfinished word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!partial || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count             <= '0;
      word                   <= '0;
      bus.write_data         <= '0;
      bus.write_clock_enable <= 1'b0;
      frame_error            <= 1'b0;
      word_dropped           <= 1'b0;
    end else begin
      bus.write_clock_enable <= 1'b0;
      word_dropped           <= 1'b0;
      frame_error            <= stop_error | timeout;
      if (stop_error || timeout) begin
        byte_count <= '0;
      end else if (byte_valid) begin
        word <= next_word;
        if (byte_count == LAST_BYTE) begin
          byte_count <= '0;
          if (bus.overflow) begin
            word_dropped <= 1'b1;
          end else begin
            bus.write_data         <= next_word;
            bus.write_clock_enable <= 1'b1;
          end
        end else begin
          byte_count <= byte_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial2mem.sv
// Directed bench for serial2mem at default parameters.
// A negedge monitor counts strobes and captures written words.
module tb_serial2mem;

  localparam int BIT = 104;

  logic clock;
  logic reset;
  logic rx;
  logic frame_error;
  logic word_dropped;
  logic rx_busy;

  serial2mem_if bus ();

  serial2mem dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .bus         (bus.master),
    .frame_error (frame_error),
    .word_dropped(word_dropped),
    .rx_busy     (rx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;

  int cyc;
  int nw;
  int nfe;
  int ndrop;
  int nrise;
  int fall_cyc;
  int fe_gap;
  logic busy_q;
  logic [47:0] words [0:7];

  initial begin
    cyc = 0;
    busy_q = 1'b0;
    fall_cyc = 0;
    fe_gap = -1;
  end

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.write_clock_enable) begin
      if (nw < 8) words[nw] = bus.write_data;
      nw = nw + 1;
    end
    if (frame_error) begin
      nfe = nfe + 1;
      fe_gap = cyc - fall_cyc;
    end
    if (word_dropped) ndrop = ndrop + 1;
    if (busy_q && !rx_busy) fall_cyc = cyc;
    if (!busy_q && rx_busy) nrise = nrise + 1;
    busy_q = rx_busy;
  end

  task automatic clear_counts();
    nw = 0;
    nfe = 0;
    ndrop = 0;
    nrise = 0;
    fe_gap = -1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input logic       stop,
    input int         gap
  );
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT);
    end
    rx = stop;
    wait_clk(BIT);
    rx = 1'b1;
    wait_clk(gap);
  endtask

  task automatic send_word(input logic [47:0] w);
    for (int i = 5; i >= 0; i--) begin
      send_byte(w[8*i +: 8], 1'b1, 0);
    end
    wait_clk(200);
  endtask

  task automatic check_int(
    input string name,
    input int    got,
    input int    exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_word(
    input string       name,
    input logic [47:0] got,
    input logic [47:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs_zero(input string name);
    check_word({name, " write_data"}, bus.write_data, 48'h0);
    check_int({name, " wce"}, int'(bus.write_clock_enable), 0);
    check_int({name, " frame_error"}, int'(frame_error), 0);
    check_int({name, " word_dropped"}, int'(word_dropped), 0);
    check_int({name, " rx_busy"}, int'(rx_busy), 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    bus.overflow = 1'b0;
    wait_clk(4);
    check_outs_zero("reset");
    reset = 1'b0;
    wait_clk(10);
    clear_counts();
  endtask

  task automatic test_normal();
    clear_counts();
    send_word(48'h48454C4C4F0A);
    check_int("normal strobes", nw, 1);
    check_word("normal word", words[0], 48'h48454C4C4F0A);
    check_word("normal hold", bus.write_data, 48'h48454C4C4F0A);
    check_int("normal errors", nfe, 0);
    check_int("normal drops", ndrop, 0);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(8'h11 + i), 1'b1, 0);
    end
    wait_clk(200);
    check_int("b2b strobes", nw, 2);
    check_word("b2b word0", words[0], 48'h111213141516);
    check_word("b2b word1", words[1], 48'h1718191A1B1C);
    check_int("b2b busy rises", nrise, 12);
    check_int("b2b errors", nfe, 0);
  endtask

  task automatic test_bad_stop();
    clear_counts();
    send_byte(8'h31, 1'b1, 0);
    send_byte(8'h32, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h55, 1'b0, 300);
    send_word(48'h010203040506);
    check_int("badstop errors", nfe, 1);
    check_int("badstop strobes", nw, 1);
    check_word("badstop word", words[0], 48'h010203040506);
  endtask

  task automatic test_timeout();
    clear_counts();
    send_byte(8'h77, 1'b1, 0);
    send_byte(8'h88, 1'b1, 21 * BIT);
    check_int("timeout errors", nfe, 1);
    check_int("timeout idle clocks", fe_gap, 20 * BIT);
    send_word(48'hAABBCCDDEEFF);
    check_int("timeout strobes", nw, 1);
    check_word("timeout word", words[0], 48'hAABBCCDDEEFF);
    check_int("timeout errors total", nfe, 1);
  endtask

  task automatic test_overflow();
    clear_counts();
    bus.overflow = 1'b1;
    send_word(48'hC0FFEE123456);
    check_int("ovf drops", ndrop, 1);
    check_int("ovf strobes", nw, 0);
    bus.overflow = 1'b0;
    clear_counts();
    send_word(48'h0BADF00D0001);
    check_int("ovf release strobes", nw, 1);
    check_word("ovf release word", words[0], 48'h0BADF00D0001);
    check_int("ovf release drops", ndrop, 0);
  endtask

  task automatic test_glitch_reset();
    clear_counts();
    rx = 1'b0;
    wait_clk(30);
    rx = 1'b1;
    wait_clk(300);
    check_int("glitch strobes", nw, 0);
    check_int("glitch errors", nfe, 0);
    check_int("glitch drops", ndrop, 0);
    send_byte(8'hE1, 1'b1, 0);
    send_byte(8'hE2, 1'b1, 0);
    rx = 1'b0;
    wait_clk(BIT + 3 * BIT / 2);
    reset = 1'b1;
    wait_clk(3);
    check_outs_zero("midbyte reset");
    rx = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(20);
    clear_counts();
    send_word(48'h123456789ABC);
    check_int("post-reset strobes", nw, 1);
    check_word("post-reset word", words[0], 48'h123456789ABC);
    check_int("post-reset errors", nfe, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clear_counts();
    reset = 1'b1;
    rx = 1'b1;
    bus.overflow = 1'b0;
    test_reset();
    test_normal();
    test_back_to_back();
    test_bad_stop();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
